ts_surface_scanner: RTL and testbench

Reads the 256-cell (16x16) timestamp memory through its read-only scan port and turns each stored timestamp into an 8-bit time-surface feature for the gesture classifier. One `start` pulse produces one complete frame, cells 0..255 in ascending order, on a valid/ready stream. The frame ends with a count of recently active cells. The block drives the memory's read address directly and consumes its one-cycle-latency read data.

---
 rtl/ts_surface_scanner.sv | 171 +++++++++++++++++
 tb/tb_ts_surface_scanner.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_surface_scanner.sv
// Scans the 16x16 timestamp memory once per start pulse and streams one 8-bit
// time-surface feature per cell, closing the frame with a recent-activity count.
module ts_surface_scanner #(
  parameter int unsigned WINDOW = 4096,
  parameter int unsigned SHIFT  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] now_ts,
  output logic [7:0]  bram_addr,
  input  logic [15:0] bram_dout,
  output logic        feat_valid,
  input  logic        feat_ready,
  output logic [7:0]  feat_data,
  output logic [7:0]  feat_addr,
  output logic        feat_last,
  output logic        busy,
  output logic        done,
  output logic [8:0]  active_count
);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  localparam logic [15:0] WIN = 16'(WINDOW);

  state_t      state, state_next;
  logic        done_next;
  logic        start_accept;

  logic [14:0] now_l;
  logic        s1;          // bram_addr holds a live request this cycle
  logic        s2;          // bram_dout holds data for s2_addr this cycle
  logic [7:0]  s2_addr;
  logic        all_issued;

  // Output queue: head entry drives the feat_* ports, two further skid slots
  // absorb the requests already in flight when downstream stalls.
  logic [7:0]  q_data [4];
  logic [7:0]  q_addr [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [1:0]  cnt;

  logic        push, pop, last_hs, issue;
  logic [2:0]  occ;

  logic [14:0] age;
  logic [15:0] rem, shifted;
  logic        cell_active;
  logic [7:0]  feature;

  logic        unused_bits;
  assign unused_bits = now_ts[15];

  assign feat_valid = (cnt != 2'd0);
  assign feat_data  = q_data[rd_ptr];
  assign feat_addr  = q_addr[rd_ptr];
  assign feat_last  = feat_valid && (feat_addr == 8'hFF);
  assign busy       = (state == SCAN);

  always_comb begin
    age         = now_l - bram_dout[14:0];
    cell_active = !bram_dout[15] && ({1'b0, age} < WIN);
    rem         = WIN - 16'd1 - {1'b0, age};
    shifted     = rem >> SHIFT;
    feature     = '0;
    if (cell_active) begin
      feature = (shifted > 16'd255) ? 8'hFF : shifted[7:0];
    end
  end

  // A new address is issued only if every request already in flight, plus
  // this one, still fits in the queue after this cycle's pop.
  always_comb begin
    pop     = feat_valid && feat_ready;
    push    = s2;
    last_hs = pop && feat_last;
    occ     = 3'(cnt) + 3'(s1) + 3'(s2);
    issue   = (state == SCAN) && !all_issued && ((occ - 3'(pop)) <= 3'd2);
  end

  always_comb begin
    state_next   = state;
    done_next    = 1'b0;
    start_accept = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next   = SCAN;
          start_accept = 1'b1;
        end
      end
      SCAN: begin
        if (last_hs) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= done_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      now_l        <= '0;
      bram_addr    <= '0;
      s1           <= 1'b0;
      s2           <= 1'b0;
      s2_addr      <= '0;
      all_issued   <= 1'b0;
      active_count <= '0;
    end else begin
      s2      <= s1;
      s2_addr <= bram_addr;
      if (start_accept) begin
        now_l        <= now_ts[14:0];
        bram_addr    <= '0;
        s1           <= 1'b1;
        all_issued   <= 1'b0;
        active_count <= '0;
      end else begin
        if (issue) begin
          bram_addr  <= bram_addr + 8'd1;
          s1         <= 1'b1;
          all_issued <= (bram_addr == 8'd254);
        end else begin
          s1 <= 1'b0;
        end
        if (push && cell_active) begin
          active_count <= active_count + 9'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        q_data[i] <= '0;
        q_addr[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        q_data[wr_ptr] <= feature;
        q_addr[wr_ptr] <= s2_addr;
        wr_ptr         <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_ts_surface_scanner.sv
// Directed bench for ts_surface_scanner with a one-cycle-latency memory model.
module tb_ts_surface_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] now_ts = '0;
  logic [7:0]  bram_addr;
  logic [15:0] bram_dout;
  logic        feat_valid;
  logic        feat_ready = 1'b0;
  logic [7:0]  feat_data;
  logic [7:0]  feat_addr;
  logic        feat_last;
  logic        busy;
  logic        done;
  logic [8:0]  active_count;

  ts_surface_scanner #(.WINDOW(4096), .SHIFT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .now_ts(now_ts),
    .bram_addr(bram_addr), .bram_dout(bram_dout),
    .feat_valid(feat_valid), .feat_ready(feat_ready), .feat_data(feat_data),
    .feat_addr(feat_addr), .feat_last(feat_last), .busy(busy), .done(done),
    .active_count(active_count)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [256];
  always @(posedge clk) bram_dout <= mem[bram_addr];

  int checks = 0;
  int passed = 0;

  int          beat_addr [512];
  logic [7:0]  beat_data [256];
  logic [7:0]  exp_data  [256];
  int          nbeats, last_count, last_pos, stable_err, stall_cycles;
  int          done_idx, first_valid_idx, first_bad;
  logic        timed_out, start_busy, done_busy;
  logic [7:0]  start_addr;
  logic [8:0]  done_count;

  task automatic fill_empty();
    for (int i = 0; i < 256; i++) begin
      mem[i]      = 16'h8000;
      exp_data[i] = 8'd0;
    end
  endtask

  function automatic int seq_errors();
    int e = 0;
    first_bad = -1;
    for (int i = 0; i < 256; i++) begin
      if (i >= nbeats || beat_addr[i] != i) begin
        e++;
        if (first_bad < 0) first_bad = i;
      end
    end
    return e;
  endfunction

  function automatic int data_errors();
    int e = 0;
    first_bad = -1;
    for (int i = 0; i < 256; i++) begin
      if (beat_data[i] !== exp_data[i]) begin
        e++;
        if (first_bad < 0) first_bad = i;
      end
    end
    return e;
  endfunction

  // Runs one frame; idx counts negedges after the accepting edge T0 (idx k follows edge Tk).
  task automatic collect(input logic [15:0] ts, input int mode, input int mid_idx);
    logic       prev_stall;
    logic [7:0] pd, pa;
    logic       pl;
    nbeats = 0; last_count = 0; last_pos = -1; stable_err = 0; stall_cycles = 0;
    done_idx = -1; first_valid_idx = -1; timed_out = 1'b0; done_count = 'x; done_busy = 1'bx;
    for (int i = 0; i < 256; i++) beat_data[i] = 'x;
    prev_stall = 1'b0; pd = '0; pa = '0; pl = 1'b0;
    @(negedge clk);
    start = 1'b1; now_ts = ts;
    @(negedge clk);
    start = 1'b0; now_ts = 16'h1234;
    start_busy = busy; start_addr = bram_addr;
    for (int idx = 0; idx < 3000; idx++) begin
      if (idx > 0) @(negedge clk);
      start = (idx == mid_idx);
      feat_ready = (mode == 0) ? 1'b1 : !((idx % 4 == 1) || (idx % 4 == 2));
      if (feat_valid && first_valid_idx < 0) first_valid_idx = idx;
      if (prev_stall && (!feat_valid || feat_data !== pd || feat_addr !== pa || feat_last !== pl))
        stable_err++;
      prev_stall = feat_valid && !feat_ready;
      if (prev_stall) stall_cycles++;
      pd = feat_data; pa = feat_addr; pl = feat_last;
      if (feat_valid && feat_ready) begin
        if (nbeats < 512) beat_addr[nbeats] = int'(feat_addr);
        nbeats++;
        beat_data[feat_addr] = feat_data;
        if (feat_last) begin
          last_count++;
          last_pos = int'(feat_addr);
        end
      end
      if (done) begin
        done_idx = idx; done_count = active_count; done_busy = busy;
        break;
      end
    end
    if (done_idx < 0) timed_out = 1'b1;
    start = 1'b0;
    feat_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; feat_ready = 1'b0;
    fill_empty();
    repeat (3) @(negedge clk);
    checks++;
    if ({bram_addr, feat_valid, feat_data, feat_addr, feat_last} !== '0)
      $display("FAIL reset_stream: got %h want 0", {bram_addr, feat_valid, feat_data, feat_addr, feat_last});
    else passed++;
    checks++;
    if ({busy, done} !== 2'b00) $display("FAIL reset_busy_done: got %b want 00", {busy, done});
    else passed++;
    checks++;
    if (active_count !== 9'd0) $display("FAIL reset_count: got %0d want 0", active_count);
    else passed++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || feat_valid !== 1'b0) $display("FAIL idle_after_reset: busy %b valid %b want 0 0", busy, feat_valid);
    else passed++;
  endtask

  task automatic test_empty_frame();
    int e;
    fill_empty();
    collect(16'd100, 0, -1);
    checks++;
    if (timed_out !== 1'b0) $display("FAIL empty_timeout: no done within budget");
    else passed++;
    checks++;
    if (start_busy !== 1'b1 || start_addr !== 8'd0)
      $display("FAIL empty_start: busy %b addr %0d want 1 0", start_busy, start_addr);
    else passed++;
    checks++;
    if (first_valid_idx != 2) $display("FAIL empty_latency: first valid after T%0d want T2", first_valid_idx);
    else passed++;
    checks++;
    if (nbeats != 256) $display("FAIL empty_beats: got %0d want 256", nbeats);
    else passed++;
    e = seq_errors();
    checks++;
    if (e != 0) $display("FAIL empty_seq: %0d bad, first at beat %0d want 0 bad", e, first_bad);
    else passed++;
    e = data_errors();
    checks++;
    if (e != 0) $display("FAIL empty_data: %0d bad, cell %0d got %h want %h", e, first_bad,
                         beat_data[first_bad], exp_data[first_bad]);
    else passed++;
    checks++;
    if (last_count != 1 || last_pos != 255) $display("FAIL empty_last: count %0d pos %0d want 1 255", last_count, last_pos);
    else passed++;
    checks++;
    if (done_idx != 258) $display("FAIL empty_done_time: done after T%0d want T258", done_idx);
    else passed++;
    checks++;
    if (done_busy !== 1'b0) $display("FAIL empty_busy_at_done: got %b want 0", done_busy);
    else passed++;
    checks++;
    if (done_count !== 9'd0) $display("FAIL empty_count: got %0d want 0", done_count);
    else passed++;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) $display("FAIL done_pulse_width: done still %b want 0", done);
    else passed++;
  endtask

  task automatic test_fresh_cell();
    int e;
    fill_empty();
    mem[17] = 16'h0064; exp_data[17] = 8'd255;
    collect(16'h0064, 0, -1);
    e = data_errors();
    checks++;
    if (timed_out || e != 0) $display("FAIL fresh_data: timeout %b, %0d bad, first cell %0d want 0 bad", timed_out, e, first_bad);
    else passed++;
    checks++;
    if (done_count !== 9'd1) $display("FAIL fresh_count: got %0d want 1", done_count);
    else passed++;
    repeat (5) @(negedge clk);
    checks++;
    if (active_count !== 9'd1) $display("FAIL count_hold: got %0d want 1", active_count);
    else passed++;
  endtask

  task automatic test_wrap();
    int e;
    fill_empty();
    mem[3] = 16'h7FF0; exp_data[3] = 8'd253;
    collect(16'h0010, 0, -1);
    checks++;
    if (beat_data[3] !== 8'd253) $display("FAIL wrap_feature: got %0d want 253", beat_data[3]);
    else passed++;
    e = data_errors();
    checks++;
    if (timed_out || e != 0) $display("FAIL wrap_data: timeout %b, %0d bad want 0", timed_out, e);
    else passed++;
    checks++;
    if (done_count !== 9'd1) $display("FAIL wrap_count: got %0d want 1", done_count);
    else passed++;
  endtask

  task automatic test_window_edge();
    int e;
    fill_empty();
    mem[5] = 16'h1000;  // age 4096
    mem[6] = 16'h1001;  // age 4095
    mem[7] = 16'hA000;  // empty marker with timestamp equal to now
    collect(16'h2000, 0, -1);
    e = data_errors();
    checks++;
    if (timed_out || e != 0) $display("FAIL edge_data: timeout %b, %0d bad, first cell %0d want 0 bad", timed_out, e, first_bad);
    else passed++;
    checks++;
    if (done_count !== 9'd1) $display("FAIL edge_count: got %0d want 1", done_count);
    else passed++;
  endtask

  task automatic test_backpressure();
    int e;
    fill_empty();
    mem[17]  = 16'h0064; exp_data[17]  = 8'd255;
    mem[200] = 16'h7F64; exp_data[200] = 8'd239;  // age 256
    collect(16'h0064, 1, 50);
    checks++;
    if (timed_out !== 1'b0 || nbeats != 256) $display("FAIL bp_beats: timeout %b beats %0d want 0 256", timed_out, nbeats);
    else passed++;
    e = seq_errors();
    checks++;
    if (e != 0) $display("FAIL bp_seq: %0d bad, first at beat %0d want 0 bad", e, first_bad);
    else passed++;
    checks++;
    if (stall_cycles == 0 || stable_err != 0)
      $display("FAIL bp_stable: stalls %0d unstable %0d want >0 and 0", stall_cycles, stable_err);
    else passed++;
    e = data_errors();
    checks++;
    if (e != 0) $display("FAIL bp_data: %0d bad, cell %0d got %h want %h", e, first_bad,
                         beat_data[first_bad], exp_data[first_bad]);
    else passed++;
    checks++;
    if (done_count !== 9'd2 || last_count != 1) $display("FAIL bp_count: count %0d last %0d want 2 1", done_count, last_count);
    else passed++;
  endtask

  task automatic test_reset_mid_scan();
    int e;
    int found;
    int done_seen;
    fill_empty();
    mem[17]  = 16'h0064; exp_data[17]  = 8'd255;
    mem[200] = 16'h7F64; exp_data[200] = 8'd239;
    found = 0; done_seen = 0;
    @(negedge clk);
    start = 1'b1; now_ts = 16'h0064;
    @(negedge clk);
    start = 1'b0; feat_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (feat_valid && feat_addr == 8'd100) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (found != 1) $display("FAIL rst_reach_cell100: not reached within budget");
    else passed++;
    rst = 1'b1;
    #1;
    checks++;
    if ({bram_addr, feat_valid, feat_data, feat_addr, feat_last, busy, done, active_count} !== '0)
      $display("FAIL rst_mid_outputs: got %h want 0",
               {bram_addr, feat_valid, feat_data, feat_addr, feat_last, busy, done, active_count});
    else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    checks++;
    if (done_seen != 0) $display("FAIL rst_no_done: %0d cycles with done/busy want 0", done_seen);
    else passed++;
    collect(16'h0064, 0, -1);
    e = seq_errors();
    checks++;
    if (timed_out || nbeats != 256 || e != 0)
      $display("FAIL rst_refresh_frame: timeout %b beats %0d seq bad %0d want 0 256 0", timed_out, nbeats, e);
    else passed++;
    e = data_errors();
    checks++;
    if (e != 0 || done_count !== 9'd2) $display("FAIL rst_refresh_data: bad %0d count %0d want 0 2", e, done_count);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_empty_frame();
    test_fresh_cell();
    test_wrap();
    test_window_edge();
    test_backpressure();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
